// File: rtl/btn_step_conditioner_pkg.sv
// Shared definitions for push-button input conditioning blocks.
// Latency: none (types and helpers only).
// Backpressure: not applicable.
package btn_step_conditioner_pkg;

  // Debounce FSM encoding, shared with the other board-input blocks.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_HELD       = 2'd2,
    ST_REL_WAIT   = 2'd3
  } btn_state_e;

  // Larger of two integers, used to size the shared counter width.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_step_conditioner_sync2.sv
// Two-flop synchroniser for one asynchronous level into the clk domain.
// Latency: 2 cycles from d sampled to q.
// Backpressure: none, free-running.
module btn_step_conditioner_sync2 (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  // Shift the raw level through two stages.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchroniser stages, cleared synchronously so a reset drops any stale level.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_step_conditioner.sv
// Turns a raw push-button level into debounced level plus single-cycle press/release strobes.
// Latency: input stable from posedge k -> strobe in the cycle after posedge k+DEBOUNCE_CYCLES+2.
// Backpressure: none; strobes are fire-and-forget one-cycle events.
module btn_step_conditioner
  import btn_step_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic busy
);

  // Counter width is derived so both debounce and repeat terminal counts fit.
  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);
  localparam bit RPT_EN = (REPEAT_CYCLES > 0);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = RPT_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  logic       btn_sync;
  btn_state_e state_d, state_q;
  logic [CNT_W-1:0] deb_cnt_d, deb_cnt_q;
  logic [CNT_W-1:0] rpt_cnt_d, rpt_cnt_q;
  logic btn_level_d, btn_level_q;
  logic press_pulse_d, press_pulse_q;
  logic release_pulse_d, release_pulse_q;
  logic busy_d, busy_q;

  // The FSM only ever observes the synchronised level.
  btn_step_conditioner_sync2 u_sync2 (
    .clk (clk),
    .clr (clr),
    .d   (btn_in),
    .q   (btn_sync)
  );

  // State, counters and registered outputs; clr discards any debounce progress.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q         <= ST_IDLE;
      deb_cnt_q       <= '0;
      rpt_cnt_q       <= '0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      rpt_cnt_q       <= rpt_cnt_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      busy_q          <= busy_d;
    end
  end

  // Next state and counter updates; counters reload on entry and never wrap.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_sync) begin
          state_d   = ST_PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = ST_IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = ST_HELD;
          rpt_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        // Leaving HELD takes priority over a repeat terminal count.
        if (!btn_sync) begin
          state_d   = ST_REL_WAIT;
          deb_cnt_d = '0;
        end else if (RPT_EN) begin
          if (rpt_cnt_q == RPT_LAST) begin
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_REL_WAIT: begin
        if (btn_sync) begin
          state_d   = ST_HELD;
          rpt_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode feeding the output flops; strobes mirror the terminal transitions above.
  always_comb begin
    press_pulse_d = 1'b0;
    if (state_q == ST_PRESS_WAIT && btn_sync && deb_cnt_q == DEB_LAST) begin
      press_pulse_d = 1'b1;
    end
    if (RPT_EN && state_q == ST_HELD && btn_sync && rpt_cnt_q == RPT_LAST) begin
      press_pulse_d = 1'b1;
    end
    release_pulse_d = (state_q == ST_REL_WAIT) && !btn_sync && (deb_cnt_q == DEB_LAST);
    btn_level_d     = (state_d == ST_HELD) || (state_d == ST_REL_WAIT);
    busy_d          = (state_d == ST_PRESS_WAIT) || (state_d == ST_REL_WAIT);
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Bench for btn_step_conditioner: instance A without auto-repeat, instance B with repeat period 5.
// Expected strobes are queued as (cycle, kind) and matched by per-instance monitors.
// Level/busy are checked directly at chosen cycles.
module tb_btn_step_conditioner;

  typedef struct {
    int cyc;
    bit is_press;
  } exp_t;

  logic clk;
  int   cyc;
  int   n_checks;
  int   n_pass;

  logic clr_a, btn_a, lvl_a, prs_a, rel_a, busy_a;
  logic clr_b, btn_b, lvl_b, prs_b, rel_b, busy_b;

  exp_t q_a[$];
  exp_t q_b[$];

  btn_step_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) dut_a (
    .clk           (clk),
    .clr           (clr_a),
    .btn_in        (btn_a),
    .btn_level     (lvl_a),
    .press_pulse   (prs_a),
    .release_pulse (rel_a),
    .busy          (busy_a)
  );

  btn_step_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(5)) dut_b (
    .clk           (clk),
    .clr           (clr_b),
    .btn_in        (btn_b),
    .btn_level     (lvl_b),
    .press_pulse   (prs_b),
    .release_pulse (rel_b),
    .busy          (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of posedges seen so far
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Advance to the negedge following posedge k.
  task automatic at_neg(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Monitor A: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (prs_a === 1'b1 && rel_a === 1'b1) chk("a_coincide", 1, 0);
    if (prs_a === 1'b1 || rel_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_pulse", cyc, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk(e.is_press ? "a_press_cycle" : "a_release_cycle", cyc, e.cyc);
        chk("a_pulse_kind", {31'd0, prs_a}, {31'd0, e.is_press});
      end
    end
  end

  // Monitor B: same matching for the auto-repeat instance.
  always @(negedge clk) begin
    if (prs_b === 1'b1 && rel_b === 1'b1) chk("b_coincide", 1, 0);
    if (prs_b === 1'b1 || rel_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_pulse", cyc, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk(e.is_press ? "b_press_cycle" : "b_release_cycle", cyc, e.cyc);
        chk("b_pulse_kind", {31'd0, prs_b}, {31'd0, e.is_press});
      end
    end
  end

  // Instance A: reset with button held, clean press/release, bounces, reset mid-debounce.
  task automatic seq_a();
    int exp_busy[5];
    clr_a = 1'b1;
    btn_a = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      at_neg(k);
      chk("a_rst_outputs", {28'd0, lvl_a, prs_a, rel_a, busy_a}, 32'd0);
    end
    clr_a = 1'b0;                          // button stable high from posedge 4
    q_a.push_back('{10, 1'b1});
    at_neg(9);  chk("a_busy_pw", busy_a, 1); chk("a_lvl_pre", lvl_a, 0);
    at_neg(10); chk("a_lvl_held", lvl_a, 1); chk("a_busy_held", busy_a, 0);
    at_neg(19); btn_a = 1'b0;              // low from posedge 20
    q_a.push_back('{26, 1'b0});
    at_neg(22); chk("a_busy_rw", busy_a, 1); chk("a_lvl_rw", lvl_a, 1);
    at_neg(26); chk("a_lvl_released", lvl_a, 0);

    at_neg(29); btn_a = 1'b1;              // clean press from posedge 30
    q_a.push_back('{36, 1'b1});
    at_neg(35); chk("a_lvl_before_accept", lvl_a, 0);
    at_neg(36); chk("a_lvl_accept", lvl_a, 1);
    at_neg(39); btn_a = 1'b0;
    q_a.push_back('{46, 1'b0});

    // bounce: high at 50,51, low 52, high 53, low after
    at_neg(49); btn_a = 1'b1;
    at_neg(51); btn_a = 1'b0;
    at_neg(52); btn_a = 1'b1;
    at_neg(53); btn_a = 1'b0;
    exp_busy = '{1, 1, 0, 1, 0};
    for (int k = 52; k <= 56; k++) begin
      at_neg(k);
      chk("a_bounce_busy", busy_a, exp_busy[k-52]);
      chk("a_bounce_lvl", lvl_a, 0);
    end

    at_neg(69); btn_a = 1'b1;              // hold from 70
    q_a.push_back('{76, 1'b1});
    at_neg(99); btn_a = 1'b0;              // release from 100
    q_a.push_back('{106, 1'b0});
    at_neg(105); chk("a_lvl_hold", lvl_a, 1);
    at_neg(106); chk("a_lvl_drop", lvl_a, 0);

    // reset while PRESS_WAIT with deb_cnt=2 (after posedge 124)
    at_neg(119); btn_a = 1'b1;
    at_neg(124); chk("a_busy_before_clr", busy_a, 1); clr_a = 1'b1;
    at_neg(125); chk("a_clr_mid", {28'd0, lvl_a, prs_a, rel_a, busy_a}, 32'd0); clr_a = 1'b0;
    q_a.push_back('{132, 1'b1});           // full debounce restarts from posedge 126
    at_neg(127); chk("a_idle_after_clr", busy_a, 0);
    at_neg(128); chk("a_pw_after_clr", busy_a, 1);
    at_neg(132); chk("a_lvl_after_clr", lvl_a, 1);

    // release bounce: low at 140 only, back high -> REL_WAIT then HELD, no pulse
    at_neg(139); btn_a = 1'b0;
    at_neg(140); btn_a = 1'b1;
    at_neg(142); chk("a_relbounce_busy", busy_a, 1);
    at_neg(143); chk("a_relbounce_back", busy_a, 0); chk("a_relbounce_lvl", lvl_a, 1);
    at_neg(149); btn_a = 1'b0;             // final release from 150
    q_a.push_back('{156, 1'b0});
    at_neg(170);
  endtask

  // Instance B: auto-repeat every 5 cycles, exit coinciding with repeat terminal.
  task automatic seq_b();
    clr_b = 1'b1;
    btn_b = 1'b0;
    at_neg(3); clr_b = 1'b0;
    at_neg(9); btn_b = 1'b1;               // press from posedge 10
    q_b.push_back('{16, 1'b1});
    for (int r = 1; r <= 6; r++) q_b.push_back('{16 + 5 * r, 1'b1});
    at_neg(48); btn_b = 1'b0;              // low from 49: HELD exit at 51 = repeat terminal
    q_b.push_back('{55, 1'b0});
    at_neg(51); chk("b_exit_busy", busy_b, 1);
    at_neg(55); chk("b_lvl_released", lvl_b, 0);
    at_neg(170);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    fork
      seq_a();
      seq_b();
    join
    chk("a_missing_pulses", q_a.size(), 0);
    chk("b_missing_pulses", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
